// File: rtl/rx_cmd_decoder.sv
// rtl/rx_cmd_decoder.sv - byte-stream frame decoder to system commands (optional FRAME_TIMEOUT_EN)
module rx_cmd_decoder #(
  parameter int Width          = 8,
  parameter int ADDR_W         = 4,
  parameter int FUN_W          = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [Width-1:0]  RX_P_Data,
  input  logic              RX_D_VLD,
  input  logic              Cmd_Ready,
  output logic              Cmd_Valid,
  output logic [1:0]        Cmd_Type,
  output logic [ADDR_W-1:0] Cmd_Addr,
  output logic [Width-1:0]  Cmd_WrData,
  output logic [Width-1:0]  Cmd_OpA,
  output logic [Width-1:0]  Cmd_OpB,
  output logic [FUN_W-1:0]  Cmd_Fun,
  output logic              Frame_Err,
  output logic              Overrun_Err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GET_ADDR = 3'd1;
  localparam logic [2:0] S_GET_DATA = 3'd2;
  localparam logic [2:0] S_GET_OPA  = 3'd3;
  localparam logic [2:0] S_GET_OPB  = 3'd4;
  localparam logic [2:0] S_GET_FUN  = 3'd5;
  localparam logic [2:0] S_PEND     = 3'd6;

  localparam logic [1:0] T_WR      = 2'b00;
  localparam logic [1:0] T_RD      = 2'b01;
  localparam logic [1:0] T_ALU_OP  = 2'b10;
  localparam logic [1:0] T_ALU_NOP = 2'b11;

  localparam logic [Width-1:0] OP_WR      = Width'(8'hAA);
  localparam logic [Width-1:0] OP_RD      = Width'(8'hBB);
  localparam logic [Width-1:0] OP_ALU_OP  = Width'(8'hCC);
  localparam logic [Width-1:0] OP_ALU_NOP = Width'(8'hDD);

  logic [2:0]        state_q, state_d;
  logic [1:0]        kind_q, kind_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [1:0]        cmd_type_q, cmd_type_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [Width-1:0]  cmd_wrdata_q, cmd_wrdata_d;
  logic [Width-1:0]  cmd_opa_q, cmd_opa_d;
  logic [Width-1:0]  cmd_opb_q, cmd_opb_d;
  logic [FUN_W-1:0]  cmd_fun_q, cmd_fun_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_err_q, overrun_err_d;

  logic              op_hit;
  logic [2:0]        op_state;
  logic [1:0]        op_kind;

`ifdef FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              in_frame;
`endif

  // Classify the incoming byte as a frame opcode (shared by IDLE and PEND-retire paths)
  always_comb begin
    op_hit   = 1'b1;
    op_state = S_IDLE;
    op_kind  = T_WR;
    case (RX_P_Data)
      OP_WR: begin
        op_state = S_GET_ADDR;
        op_kind  = T_WR;
      end
      OP_RD: begin
        op_state = S_GET_ADDR;
        op_kind  = T_RD;
      end
      OP_ALU_OP: begin
        op_state = S_GET_OPA;
        op_kind  = T_ALU_OP;
      end
      OP_ALU_NOP: begin
        op_state = S_GET_FUN;
        op_kind  = T_ALU_NOP;
      end
      default: op_hit = 1'b0;
    endcase
  end

  // Frame assembly FSM, field latching, handshake and error pulses
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_type_d    = cmd_type_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wrdata_d  = cmd_wrdata_q;
    cmd_opa_d     = cmd_opa_q;
    cmd_opb_d     = cmd_opb_q;
    cmd_fun_d     = cmd_fun_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (op_hit) begin
            state_d = op_state;
            kind_d  = op_kind;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      S_GET_ADDR: begin
        if (RX_D_VLD) begin
          cmd_addr_d = RX_P_Data[ADDR_W-1:0];
          if (kind_q == T_WR) begin
            state_d = S_GET_DATA;
          end else begin
            state_d     = S_PEND;
            cmd_valid_d = 1'b1;
            cmd_type_d  = kind_q;
          end
        end
      end

      S_GET_DATA: begin
        if (RX_D_VLD) begin
          cmd_wrdata_d = RX_P_Data;
          state_d      = S_PEND;
          cmd_valid_d  = 1'b1;
          cmd_type_d   = kind_q;
        end
      end

      S_GET_OPA: begin
        if (RX_D_VLD) begin
          cmd_opa_d = RX_P_Data;
          state_d   = S_GET_OPB;
        end
      end

      S_GET_OPB: begin
        if (RX_D_VLD) begin
          cmd_opb_d = RX_P_Data;
          state_d   = S_GET_FUN;
        end
      end

      S_GET_FUN: begin
        if (RX_D_VLD) begin
          cmd_fun_d   = RX_P_Data[FUN_W-1:0];
          state_d     = S_PEND;
          cmd_valid_d = 1'b1;
          cmd_type_d  = kind_q;
        end
      end

      S_PEND: begin
        if (Cmd_Ready) begin
          // Retire; a byte arriving on the same cycle starts the next frame
          cmd_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (RX_D_VLD) begin
            if (op_hit) begin
              state_d = op_state;
              kind_d  = op_kind;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end else if (RX_D_VLD) begin
          overrun_err_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase

`ifdef FRAME_TIMEOUT_EN
    // Inter-byte gap watchdog; only armed while a frame is partially assembled
    in_frame = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA) ||
               (state_q == S_GET_OPA)  || (state_q == S_GET_OPB)  ||
               (state_q == S_GET_FUN);
    if (RX_D_VLD || !in_frame) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
      tmo_cnt_d   = '0;
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
`endif
  end

  // State and output registers; reset discards any partial or pending frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      kind_q        <= T_WR;
      cmd_valid_q   <= 1'b0;
      cmd_type_q    <= 2'b00;
      cmd_addr_q    <= '0;
      cmd_wrdata_q  <= '0;
      cmd_opa_q     <= '0;
      cmd_opb_q     <= '0;
      cmd_fun_q     <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_type_q    <= cmd_type_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wrdata_q  <= cmd_wrdata_d;
      cmd_opa_q     <= cmd_opa_d;
      cmd_opb_q     <= cmd_opb_d;
      cmd_fun_q     <= cmd_fun_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  // Timeout counter register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign Cmd_Valid   = cmd_valid_q;
  assign Cmd_Type    = cmd_type_q;
  assign Cmd_Addr    = cmd_addr_q;
  assign Cmd_WrData  = cmd_wrdata_q;
  assign Cmd_OpA     = cmd_opa_q;
  assign Cmd_OpB     = cmd_opb_q;
  assign Cmd_Fun     = cmd_fun_q;
  assign Frame_Err   = frame_err_q;
  assign Overrun_Err = overrun_err_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// tb/tb_rx_cmd_decoder.sv - randomized and directed bench for rx_cmd_decoder against a frame-level model
module tb_rx_cmd_decoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_Data = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic       Cmd_Ready = 1'b0;
  logic       Cmd_Valid;
  logic [1:0] Cmd_Type;
  logic [3:0] Cmd_Addr;
  logic [7:0] Cmd_WrData;
  logic [7:0] Cmd_OpA;
  logic [7:0] Cmd_OpB;
  logic [3:0] Cmd_Fun;
  logic       Frame_Err;
  logic       Overrun_Err;

  int total = 0;
  int bad   = 0;

`ifdef FRAME_TIMEOUT_EN
  localparam int TMO = 16;
  rx_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
`else
  rx_cmd_decoder dut (
`endif
    .CLK(CLK), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
    .Cmd_Ready(Cmd_Ready), .Cmd_Valid(Cmd_Valid), .Cmd_Type(Cmd_Type),
    .Cmd_Addr(Cmd_Addr), .Cmd_WrData(Cmd_WrData), .Cmd_OpA(Cmd_OpA),
    .Cmd_OpB(Cmd_OpB), .Cmd_Fun(Cmd_Fun), .Frame_Err(Frame_Err),
    .Overrun_Err(Overrun_Err)
  );

  always #5 CLK = ~CLK;

  // Frame-level reference: bytes of the frame in progress plus the expected outputs
  logic [7:0] m_frame[$];
  logic       m_valid, m_ferr, m_ovr;
  logic [1:0] m_type;
  logic [3:0] m_addr, m_fun;
  logic [7:0] m_wr, m_opa, m_opb;
  int         m_gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_frame.delete();
    m_valid = 0; m_ferr = 0; m_ovr = 0; m_type = 0;
    m_addr = 0; m_fun = 0; m_wr = 0; m_opa = 0; m_opb = 0; m_gap = 0;
  endtask

  function automatic int frame_len(input logic [7:0] op);
    case (op)
      8'hAA: return 3;
      8'hBB: return 2;
      8'hCC: return 4;
      8'hDD: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] frame_type(input logic [7:0] op);
    case (op)
      8'hAA: return 2'd0;
      8'hBB: return 2'd1;
      8'hCC: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Predict the outputs after one clock with the given inputs
  task automatic m_step(input logic v, input logic [7:0] d, input logic r);
    logic [7:0] op;
    int idx;
    m_ferr = 0;
    m_ovr  = 0;
    if (m_valid) begin
      if (r) m_valid = 0;
      else if (v) m_ovr = 1;
    end
    if (v && !m_valid) begin
      m_gap = 0;
      m_frame.push_back(d);
      op  = m_frame[0];
      idx = m_frame.size() - 1;
      if (frame_len(op) == 0) begin
        m_ferr = 1;
        m_frame.delete();
      end else begin
        if (idx == 1) begin
          if (op == 8'hCC) m_opa = d;
          else if (op == 8'hDD) m_fun = d[3:0];
          else m_addr = d[3:0];
        end else if (idx == 2) begin
          if (op == 8'hAA) m_wr = d;
          else m_opb = d;
        end else if (idx == 3) begin
          m_fun = d[3:0];
        end
        if (m_frame.size() == frame_len(op)) begin
          m_valid = 1;
          m_type  = frame_type(op);
          m_frame.delete();
        end
      end
    end
`ifdef FRAME_TIMEOUT_EN
    else if (!v && m_frame.size() > 0) begin
      if (m_gap == TMO) begin
        m_ferr = 1;
        m_gap  = 0;
        m_frame.delete();
      end else begin
        m_gap++;
      end
    end
`endif
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".valid"}, Cmd_Valid, m_valid);
    chk({ctx, ".ferr"}, Frame_Err, m_ferr);
    chk({ctx, ".ovr"}, Overrun_Err, m_ovr);
    chk({ctx, ".type"}, Cmd_Type, m_type);
    chk({ctx, ".addr"}, Cmd_Addr, m_addr);
    chk({ctx, ".wr"}, Cmd_WrData, m_wr);
    chk({ctx, ".opa"}, Cmd_OpA, m_opa);
    chk({ctx, ".opb"}, Cmd_OpB, m_opb);
    chk({ctx, ".fun"}, Cmd_Fun, m_fun);
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check
  task automatic step(input string ctx, input logic v, input logic [7:0] d, input logic r);
    RX_D_VLD  = v;
    RX_P_Data = d;
    Cmd_Ready = r;
    m_step(v, d, r);
    @(negedge CLK);
    check_outputs(ctx);
  endtask

  task automatic do_reset(input string ctx);
    RX_D_VLD = 0;
    RST = 0;
    m_reset();
    #2;
    check_outputs(ctx);
    @(negedge CLK);
    RST = 1;
  endtask

  initial begin
    logic [7:0] ops[4];
    logic [7:0] b;
    ops[0] = 8'hAA; ops[1] = 8'hBB; ops[2] = 8'hCC; ops[3] = 8'hDD;
    m_reset();
    @(negedge CLK);
    do_reset("reset");

    // Write frame with consumer always ready
    step("t1", 1, 8'hAA, 1);
    step("t1", 1, 8'h05, 1);
    step("t1", 1, 8'h3C, 1);
    chk("t1.valid_set", Cmd_Valid, 1);
    chk("t1.type_wr", Cmd_Type, 0);
    chk("t1.addr5", Cmd_Addr, 5);
    chk("t1.wr3c", Cmd_WrData, 8'h3C);
    step("t1", 0, 8'h00, 1);
    chk("t1.valid_one_cycle", Cmd_Valid, 0);

    // ALU frame held pending for 10 cycles
    step("t2", 1, 8'hCC, 0);
    step("t2", 1, 8'h12, 0);
    step("t2", 1, 8'h34, 0);
    step("t2", 1, 8'h03, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t2.valid_held", Cmd_Valid, 1);
      chk("t2.opb_held", Cmd_OpB, 8'h34);
      step("t2", 0, 8'h00, (i == 9));
    end
    chk("t2.valid_cleared", Cmd_Valid, 0);
    chk("t2.type_alu", Cmd_Type, 2);
    chk("t2.opa", Cmd_OpA, 8'h12);
    chk("t2.fun", Cmd_Fun, 3);

    // Bad opcode, then read frame
    step("t3", 1, 8'h7E, 0);
    chk("t3.ferr", Frame_Err, 1);
    chk("t3.no_valid", Cmd_Valid, 0);
    step("t3", 0, 8'h00, 0);
    chk("t3.ferr_pulse", Frame_Err, 0);
    step("t3", 1, 8'hBB, 0);
    step("t3", 1, 8'h02, 1);
    chk("t3.type_rd", Cmd_Type, 1);
    chk("t3.addr2", Cmd_Addr, 2);
    step("t3", 0, 8'h00, 1);

    // Overrun while pending, then retire coinciding with a new opcode
    step("t4", 1, 8'hDD, 0);
    step("t4", 1, 8'h01, 0);
    step("t4", 1, 8'hBB, 0);
    chk("t4.ovr", Overrun_Err, 1);
    chk("t4.fun_kept", Cmd_Fun, 1);
    chk("t4.still_valid", Cmd_Valid, 1);
    step("t4", 1, 8'hBB, 1);
    chk("t4.retired", Cmd_Valid, 0);
    chk("t4.no_ovr", Overrun_Err, 0);
    step("t4", 1, 8'h09, 0);
    chk("t4.rd_after_retire", Cmd_Valid, 1);
    chk("t4.rd_addr9", Cmd_Addr, 9);
    step("t4", 0, 8'h00, 1);

    // Reset in the middle of a frame
    step("t5", 1, 8'hAA, 0);
    step("t5", 1, 8'h05, 0);
    do_reset("t5.rst");
    chk("t5.addr_zero", Cmd_Addr, 0);
    step("t5", 1, 8'hDD, 0);
    step("t5", 1, 8'h04, 0);
    chk("t5.type_nop", Cmd_Type, 3);
    chk("t5.fun4", Cmd_Fun, 4);
    step("t5", 0, 8'h00, 1);

`ifdef FRAME_TIMEOUT_EN
    // Abandoned frame times out
    step("t6", 1, 8'hCC, 0);
    for (int i = 0; i < TMO; i++) step("t6", 0, 8'h00, 0);
    chk("t6.no_early_err", Frame_Err, 0);
    step("t6", 0, 8'h00, 0);
    chk("t6.timeout_err", Frame_Err, 1);
    chk("t6.no_valid", Cmd_Valid, 0);
    step("t6", 1, 8'hDD, 0);
    step("t6", 1, 8'h02, 0);
    chk("t6.nop_after", Cmd_Fun, 2);
    step("t6", 0, 8'h00, 1);
`endif

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset("rnd.rst");
      end else begin
        if (m_frame.size() == 0 && $urandom_range(0, 7) != 0)
          b = ops[$urandom_range(0, 3)];
        else
          b = 8'($urandom);
        step("rnd", ($urandom_range(0, 2) != 0), b, ($urandom_range(0, 3) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
